// File: rtl/compander_scheduler_pkg.sv
// Shared definitions for the compander scheduler: FSM encoding, code width
// and the bit-width helper used to size tags, pointers and counters.
package compander_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_e;

  localparam int CODE_W = 9;

  // Number of bits needed to represent value (log2(7) = 3, log2(8) = 4).
  function automatic int log2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      v = v >> 1;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/compander_scheduler_result_fifo.sv
// Show-ahead result FIFO holding {tag, code} pairs returned by the compander.
// Writes into a full FIFO are dropped; the parent flags that as overflow.
module compander_scheduler_result_fifo
  import compander_scheduler_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = log2(DEPTH - 1);
  localparam int CW = log2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr    = i_wr && !o_full;
  assign w_rd    = i_rd && !o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];

  // Storage needs no reset: it is only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/compander_scheduler.sv
// Round-robin, credit-gated scheduler sharing one compander pipeline among
// N_REQ requesters, with a tagged result FIFO and a flush/drain sequence.
module compander_scheduler
  import compander_scheduler_pkg::*;
#(
  parameter int FP_SIZE = 32,
  parameter int N_PATCH = 1024,
  parameter int PW      = log2(N_PATCH - 1),
  parameter int N_REQ   = 4,
  parameter int TW      = log2(N_REQ - 1),
  parameter int CREDITS = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*PW-1:0]      req_patch,
  input  logic [N_REQ*FP_SIZE-1:0] req_wtsum,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     dp_valid,
  output logic [PW-1:0]            dp_patch,
  output logic [FP_SIZE-1:0]       dp_wtsum,
  output logic [TW-1:0]            dp_tag,
  input  logic                     res_valid,
  input  logic [TW-1:0]            res_tag,
  input  logic [CODE_W-1:0]        res_code,
  output logic                     out_valid,
  output logic [TW-1:0]            out_tag,
  output logic [CODE_W-1:0]        out_code,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     overflow
);

  localparam int CW = log2(CREDITS);
  localparam int FW = TW + CODE_W;

  sched_state_e       r_state;
  logic               r_flush_done;
  logic [TW-1:0]      r_rr_ptr;
  logic [CW-1:0]      r_credit;
  logic               r_dp_valid;
  logic [PW-1:0]      r_dp_patch;
  logic [FP_SIZE-1:0] r_dp_wtsum;
  logic [TW-1:0]      r_dp_tag;
  logic               r_overflow;

  logic [N_REQ-1:0]   w_grant;
  logic               w_grant_any;
  logic [TW-1:0]      w_grant_idx;
  logic [TW-1:0]      w_cand;
  logic               w_hit;
  logic               w_pop;
  logic [FW-1:0]      w_head;
  logic               w_full;
  logic               w_empty;

  // Grant is gated by reset so req_ready drops the moment RESET rises.
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    w_hit       = 1'b0;
    if (!RESET && (r_state == ST_RUN) && (r_credit != '0)) begin
      for (int k = 1; k <= N_REQ; k++) begin
        w_cand      = TW'((int'(r_rr_ptr) + k) % N_REQ);
        w_hit       = !w_grant_any && req_valid[w_cand];
        w_grant_idx = w_hit ? w_cand : w_grant_idx;
        w_grant_any = w_grant_any | w_hit;
      end
      w_grant[w_grant_idx] = w_grant_any;
    end else begin
      w_grant = '0;
    end
  end

  assign w_pop = !w_empty && out_ready;

  compander_scheduler_result_fifo #(
    .DEPTH (CREDITS),
    .WIDTH (FW)
  ) u_result_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .i_wr    (res_valid),
    .i_wdata ({res_tag, res_code}),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Credits track samples granted but not yet popped by the consumer.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_credit <= CW'(CREDITS);
      r_rr_ptr <= TW'(N_REQ - 1);
    end else begin
      if (w_grant_any) begin
        r_rr_ptr <= w_grant_idx;
      end
      case ({w_grant_any, w_pop})
        2'b10:   r_credit <= r_credit - CW'(1);
        2'b01:   r_credit <= (r_credit == CW'(CREDITS)) ? r_credit : r_credit + CW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dp_valid <= 1'b0;
      r_dp_patch <= '0;
      r_dp_wtsum <= '0;
      r_dp_tag   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_dp_valid <= w_grant_any;
      if (w_grant_any) begin
        r_dp_patch <= req_patch[w_grant_idx*PW +: PW];
        r_dp_wtsum <= req_wtsum[w_grant_idx*FP_SIZE +: FP_SIZE];
        r_dp_tag   <= w_grant_idx;
      end
      if (res_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (flush) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((r_credit == CW'(CREDITS)) && w_empty) begin
            r_state      <= ST_DONE;
            r_flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!flush) begin
            r_state      <= ST_RUN;
            r_flush_done <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_flush_done <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign dp_valid   = r_dp_valid;
  assign dp_patch   = r_dp_patch;
  assign dp_wtsum   = r_dp_wtsum;
  assign dp_tag     = r_dp_tag;
  assign out_valid  = !w_empty;
  assign out_tag    = w_empty ? '0 : w_head[FW-1:CODE_W];
  assign out_code   = w_empty ? '0 : w_head[CODE_W-1:0];
  assign flush_done = r_flush_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_compander_scheduler.sv
// Randomized bench for compander_scheduler: the bench plays the compander with
// a fixed latency and predicts every output from a transaction-level model.
module tb_compander_scheduler;

  localparam int N_REQ   = 4;
  localparam int FP_SIZE = 32;
  localparam int N_PATCH = 1024;
  localparam int PW      = 10;
  localparam int TW      = 2;
  localparam int CREDITS = 16;
  localparam int CODE_W  = 9;

  logic                     CLK = 1'b0;
  logic                     RESET;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*PW-1:0]      req_patch;
  logic [N_REQ*FP_SIZE-1:0] req_wtsum;
  logic [N_REQ-1:0]         req_ready;
  logic                     dp_valid;
  logic [PW-1:0]            dp_patch;
  logic [FP_SIZE-1:0]       dp_wtsum;
  logic [TW-1:0]            dp_tag;
  logic                     res_valid;
  logic [TW-1:0]            res_tag;
  logic [CODE_W-1:0]        res_code;
  logic                     out_valid;
  logic [TW-1:0]            out_tag;
  logic [CODE_W-1:0]        out_code;
  logic                     out_ready;
  logic                     flush;
  logic                     flush_done;
  logic                     overflow;

  always #5 CLK = ~CLK;

  compander_scheduler #(
    .FP_SIZE (FP_SIZE),
    .N_PATCH (N_PATCH),
    .PW      (PW),
    .N_REQ   (N_REQ),
    .TW      (TW),
    .CREDITS (CREDITS)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_patch  (req_patch),
    .req_wtsum  (req_wtsum),
    .req_ready  (req_ready),
    .dp_valid   (dp_valid),
    .dp_patch   (dp_patch),
    .dp_wtsum   (dp_wtsum),
    .dp_tag     (dp_tag),
    .res_valid  (res_valid),
    .res_tag    (res_tag),
    .res_code   (res_code),
    .out_valid  (out_valid),
    .out_tag    (out_tag),
    .out_code   (out_code),
    .out_ready  (out_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .overflow   (overflow)
  );

  typedef struct {
    int                due;
    logic [TW-1:0]     tag;
    logic [CODE_W-1:0] code;
  } pend_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: credit count, last winner, flush phase (0 run, 1 drain, 2 done).
  int                      m_credit;
  int                      m_rr;
  int                      m_phase;
  logic                    m_ovf;
  logic                    m_done;
  logic                    m_dp_valid;
  logic [TW-1:0]           m_dp_tag;
  logic [PW-1:0]           m_dp_patch;
  logic [FP_SIZE-1:0]      m_dp_wtsum;
  logic [TW+CODE_W-1:0]    m_fifo[$];
  logic [TW+CODE_W-1:0]    ord_q[$];
  pend_t                   pend[$];

  int               cyc;
  int               lat;
  int               grants;
  logic [N_REQ-1:0] v_mask;
  logic             rdy;
  logic             fl;
  logic             inject;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [CODE_W-1:0] code_fn(input logic [FP_SIZE-1:0] w, input logic [TW-1:0] t);
    return w[CODE_W-1:0] ^ {t, 7'h55};
  endfunction

  task automatic model_reset();
    m_credit   = CREDITS;
    m_rr       = N_REQ - 1;
    m_phase    = 0;
    m_ovf      = 1'b0;
    m_done     = 1'b0;
    m_dp_valid = 1'b0;
    m_dp_tag   = '0;
    m_dp_patch = '0;
    m_dp_wtsum = '0;
    m_fifo.delete();
    ord_q.delete();
    pend.delete();
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    int                   g;
    int                   nphase;
    logic                 pop;
    logic                 full;
    logic [N_REQ-1:0]     exp_rdy;
    logic [TW+CODE_W-1:0] head;
    pend_t                p;
    req_valid = v_mask;
    for (int i = 0; i < N_REQ; i++) begin
      req_patch[i*PW +: PW]           = PW'($urandom);
      req_wtsum[i*FP_SIZE +: FP_SIZE] = $urandom;
    end
    out_ready = rdy;
    flush     = fl;
    res_valid = 1'b0;
    res_tag   = '0;
    res_code  = '0;
    if (inject) begin
      res_valid = 1'b1;
      res_tag   = 2'd3;
      res_code  = CODE_W'($urandom);
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      res_valid = 1'b1;
      res_tag   = pend[0].tag;
      res_code  = pend[0].code;
      pend.delete(0);
    end
    #2;
    g = -1;
    if (m_phase == 0 && m_credit > 0) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (g < 0 && v_mask[(m_rr + k) % N_REQ]) g = (m_rr + k) % N_REQ;
      end
    end
    exp_rdy = (g >= 0) ? (N_REQ'(1) << g) : '0;
    head    = (m_fifo.size() > 0) ? m_fifo[0] : '0;
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("dp_valid", dp_valid, m_dp_valid);
    check_eq("dp_tag", dp_tag, m_dp_tag);
    check_eq("dp_patch", dp_patch, m_dp_patch);
    check_eq("dp_wtsum", dp_wtsum, m_dp_wtsum);
    check_eq("out_valid", out_valid, m_fifo.size() > 0);
    check_eq("out_tag", out_tag, head[TW+CODE_W-1:CODE_W]);
    check_eq("out_code", out_code, head[CODE_W-1:0]);
    check_eq("flush_done", flush_done, m_done);
    check_eq("overflow", overflow, m_ovf);
    if (req_ready != '0) grants++;
    if (dp_valid) begin
      p.due  = cyc + lat;
      p.tag  = dp_tag;
      p.code = code_fn(dp_wtsum, dp_tag);
      pend.push_back(p);
    end
    pop  = (m_fifo.size() > 0) && rdy;
    full = (m_fifo.size() == CREDITS);
    if (pop) begin
      if (ord_q.size() > 0) begin
        check_eq("order", {out_tag, out_code}, ord_q[0]);
        ord_q.delete(0);
      end else begin
        check_eq("order_depth", ord_q.size(), 1);
      end
    end
    nphase = m_phase;
    case (m_phase)
      0:       if (fl) nphase = 1;
      1:       if (m_credit == CREDITS && m_fifo.size() == 0) nphase = 2;
      default: if (!fl) nphase = 0;
    endcase
    if (g >= 0 && !pop) m_credit--;
    else if (pop && g < 0) m_credit++;
    m_dp_valid = (g >= 0);
    if (g >= 0) begin
      m_rr       = g;
      m_dp_tag   = TW'(g);
      m_dp_patch = req_patch[g*PW +: PW];
      m_dp_wtsum = req_wtsum[g*FP_SIZE +: FP_SIZE];
      ord_q.push_back({TW'(g), code_fn(m_dp_wtsum, TW'(g))});
    end
    if (pop) m_fifo.delete(0);
    if (res_valid) begin
      if (full) m_ovf = 1'b1;
      else m_fifo.push_back({res_tag, res_code});
    end
    m_phase = nphase;
    m_done  = (nphase == 2);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    req_valid = '0; req_patch = '0; req_wtsum = '0;
    res_valid = 1'b0; res_tag = '0; res_code = '0;
    out_ready = 1'b0; flush = 1'b0;
    v_mask = '0; rdy = 1'b0; fl = 1'b0; inject = 1'b0;
    lat = 5; cyc = 0; grants = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    step();

    // All requesters busy, consumer always ready: strict 0,1,2,3 rotation.
    v_mask = 4'hF; rdy = 1'b1;
    repeat (40) step();
    v_mask = '0;
    repeat (12) step();

    // Consumer stalled: credits cap grants at the FIFO depth.
    v_mask = 4'b0100; rdy = 1'b0; grants = 0;
    repeat (25) step();
    check_eq("credit_limit_grants", grants, 16);
    grants = 0; rdy = 1'b1;
    step();
    rdy = 1'b0;
    repeat (10) step();
    check_eq("one_pop_one_grant", grants, 1);

    // Result pushed into a full FIFO outside the credit scheme.
    v_mask = '0; inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (3) step();
    check_eq("overflow_sticky", overflow, 1);
    RESET = 1'b1;
    #1;
    check_eq("overflow_reset", overflow, 0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    cyc++;

    // Lone requester 1 is granted every cycle; adding requester 0 alternates.
    v_mask = 4'b0010; rdy = 1'b1; grants = 0;
    repeat (10) step();
    check_eq("solo_grants", grants, 10);
    v_mask = 4'b0011;
    repeat (8) step();

    // Flush with samples in flight, then resume.
    v_mask = 4'hF;
    repeat (6) step();
    fl = 1'b1;
    for (int k = 0; k < 60 && !flush_done; k++) step();
    check_eq("flush_reaches_done", flush_done, 1);
    fl = 1'b0;
    step();
    grants = 0;
    step();
    check_eq("resume_after_flush", grants, 1);

    // Random traffic, stalls and flush toggles with a different latency.
    v_mask = '0; rdy = 1'b1;
    repeat (12) step();
    lat = $urandom_range(1, 8);
    for (int n = 0; n < 300; n++) begin
      v_mask = N_REQ'($urandom);
      rdy    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) fl = ~fl;
      step();
    end

    // Asynchronous reset in the middle of a burst.
    fl = 1'b0; v_mask = 4'hF; rdy = 1'b1; lat = 5;
    repeat (20) step();
    #2;
    RESET = 1'b1;
    #1;
    check_eq("arst_req_ready", req_ready, 0);
    check_eq("arst_dp_valid", dp_valid, 0);
    check_eq("arst_dp_data", {dp_tag, dp_patch, dp_wtsum}, 0);
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_out_data", {out_tag, out_code}, 0);
    check_eq("arst_flags", {flush_done, overflow}, 0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    cyc++;
    v_mask = 4'b0100; rdy = 1'b0; grants = 0;
    repeat (22) step();
    check_eq("post_reset_credit", grants, 16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
